uart_tx_param: RTL and testbench

Parametrised UART transmitter for the serial link datapath, driven by the shared baud-rate oversampling tick generator. It serialises one character per frame: start bit, DBIT data bits LSB first, optional parity, and a configurable stop length. A single-entry holding register lets the host queue the next character while the current frame is on the line, so frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_param.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with single-entry holding register
module uart_tx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] d_in,
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [5:0] OS_LAST  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] SB_LAST  = 6'(SB_TICK - 1);
  localparam logic [3:0] N_LAST   = 4'(DBIT - 1);
  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  state_t          state_q, state_d;
  logic [5:0]      s_q, s_d;
  logic [3:0]      n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] frame_q, frame_d;
  logic            tx_q, tx_d;
  logic [DBIT-1:0] hold_q;
  logic            hold_full_q;
  logic            load;
  logic            parity_bit;

  // Parity comes from the character latched at frame start, not the shifted copy.
  assign parity_bit = (^frame_q) ^ PAR_ODD;

  assign tx_ready = ~hold_full_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx       = tx_q;

  // Load and accept are mutually exclusive: load needs full, accept needs empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end else if (tx_start && !hold_full_q) begin
      hold_q      <= d_in;
      hold_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shift_d      = shift_q;
    frame_d      = frame_q;
    tx_d         = tx_q;
    load         = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load    = 1'b1;
          shift_d = hold_q;
          frame_d = hold_q;
          tx_d    = 1'b0;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            n_d     = '0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            n_d     = n_q + 4'd1;
            if (n_q == N_LAST) begin
              if (PAR_EN) begin
                tx_d    = parity_bit;
                state_d = PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = STOP;
              end
            end else begin
              tx_d = shift_q[1];
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            tx_done_tick = 1'b1;
            s_d          = '0;
            // A held character chains straight into the next start bit.
            if (hold_full_q) begin
              load    = 1'b1;
              shift_d = hold_q;
              frame_d = hold_q;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench for uart_tx_param over four parameter sets
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [1:0] sel = 2'd0;
  int         tick_div = 1;
  int         tick_cnt = 0;
  int         cyc = 0;

  logic [3:0] txl, rdy, bsy, dn;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    tick_cnt = (tick_cnt + 1) % tick_div;
    s_tick   = (tick_cnt == 0);
  end

  uart_tx_param u0 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
    .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done_tick(dn[0]), .tx(txl[0]));
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .d_in(d_in), .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done_tick(dn[1]), .tx(txl[1]));
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .d_in(d_in), .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done_tick(dn[2]), .tx(txl[2]));
  uart_tx_param #(.DBIT(7), .SB_TICK(32)) u3 (.clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .d_in(d_in[6:0]), .tx_ready(rdy[3]), .tx_busy(bsy[3]), .tx_done_tick(dn[3]), .tx(txl[3]));

  logic m_tx, m_rdy, m_bsy, m_done;
  assign m_tx   = txl[sel];
  assign m_rdy  = rdy[sel];
  assign m_bsy  = bsy[sel];
  assign m_done = dn[sel];

  int p_dbit [4] = '{8, 8, 8, 7};
  int p_os   [4] = '{16, 16, 16, 16};
  int p_sb   [4] = '{16, 16, 16, 32};
  int p_pen  [4] = '{0, 1, 1, 0};

  typedef struct {
    logic [8:0] data;
    logic       par;
    bit         b2b;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Line monitor: rebuilds each frame from tick-cycle samples and scores it.
  bit   m_on = 0;
  int   m_t, m_bad, m_gap = 1000, first_gap, frames = 0, dones = 0;
  int   glitches = 0, stray_done = 0, t_start_cyc = 0, t_done_cyc = 0;
  logic prev_tx = 1'b1, prev_tick = 1'b0;
  logic mbits [0:15];

  task automatic finish_frame();
    exp_t       e;
    logic [8:0] data;
    int         db;
    db   = p_dbit[sel];
    data = '0;
    for (int i = 0; i < db; i++) data[i] = mbits[1 + i];
    if (exp_q.size() == 0) begin
      check("unexpected_frame", data, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("frame_data", data, e.data);
      check("frame_start_bit", mbits[0], 0);
      if (p_pen[sel] != 0) check("frame_parity", mbits[1 + db], e.par);
      check("frame_shape", m_bad, 0);
      if (e.b2b) check("back_to_back_gap", first_gap, 0);
    end
  endtask

  always @(negedge clk) begin
    int nslot, os, total;
    if (reset) begin
      m_on    = 0;
      m_gap   = 1000;
      prev_tx = 1'b1;
      prev_tick = 1'b0;
    end else begin
      if (m_tx !== prev_tx && !prev_tick && !(prev_tx === 1'b1 && m_tx === 1'b0)) glitches++;
      if (m_done) begin
        dones++;
        t_done_cyc = cyc;
      end
      if (!m_on && prev_tx === 1'b1 && m_tx === 1'b0) t_start_cyc = cyc;
      if (s_tick) begin
        if (!m_on) begin
          if (m_tx === 1'b0) begin
            m_on = 1; m_t = 0; m_bad = 0; frames++; first_gap = m_gap;
          end else if (m_gap < 1000) begin
            m_gap++;
          end
        end
        if (m_on) begin
          m_t++;
          os    = p_os[sel];
          nslot = 1 + p_dbit[sel] + p_pen[sel];
          total = nslot * os + p_sb[sel];
          if (m_t <= nslot * os) begin
            if ((m_t - 1) % os == 0) mbits[(m_t - 1) / os] = m_tx;
            else if (m_tx !== mbits[(m_t - 1) / os]) m_bad++;
          end else if (m_tx !== 1'b1) begin
            m_bad++;
          end
          if (m_done !== (m_t == total)) m_bad++;
          if (m_t == total) begin
            finish_frame();
            m_on  = 0;
            m_gap = 0;
          end
        end else if (m_done) begin
          stray_done++;
        end
      end else if (m_done) begin
        stray_done++;
      end
      prev_tx   = m_tx;
      prev_tick = s_tick;
    end
  end

  task automatic send(logic [8:0] d, logic par, bit b2b);
    exp_t e;
    e.data = d; e.par = par; e.b2b = b2b;
    exp_q.push_back(e);
    d_in     = d[7:0];
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic do_reset(logic [1:0] new_sel, int div);
    @(posedge clk); #1;
    reset    = 1'b1;
    tx_start = 1'b0;
    sel      = new_sel;
    tick_div = div;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int k = 0;
    while ((exp_q.size() != 0 || m_on) && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_within_budget", 32'(k < budget), 1);
  endtask

  initial begin
    int d0, f0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_tx", m_tx, 1);
    check("reset_ready", m_rdy, 1);
    check("reset_busy", m_bsy, 0);
    check("reset_done", m_done, 0);

    // Default frame, 0x55, with start latency and done timing
    d0 = dones;
    send(9'h055, 1'b0, 1'b0);
    check("accept_tx_still_idle", m_tx, 1);
    check("accept_ready_low", m_rdy, 0);
    check("accept_busy_low", m_bsy, 0);
    @(posedge clk); #1;
    check("start_tx_low", m_tx, 0);
    check("start_busy", m_bsy, 1);
    check("start_ready_back", m_rdy, 1);
    wait_drain(400);
    check("done_at_160", t_done_cyc - t_start_cyc + 1, 160);
    check("done_once", dones - d0, 1);
    check("idle_after_frame", m_bsy, 0);

    // Parity frames
    do_reset(2'd1, 1);
    send(9'h007, 1'b1, 1'b0);
    wait_drain(500);
    check("parity_frame_176", t_done_cyc - t_start_cyc + 1, 176);
    do_reset(2'd2, 1);
    send(9'h007, 1'b0, 1'b0);
    wait_drain(500);
    do_reset(2'd1, 1);
    send(9'h003, 1'b0, 1'b0);
    wait_drain(500);

    // DBIT=7, two stop bits, sparse ticks
    do_reset(2'd3, 3);
    send(9'h041, 1'b0, 1'b0);
    wait_drain(2000);
    check("tick_aligned_edges", glitches, 0);

    // Queue two back-to-back, third start ignored while full
    do_reset(2'd0, 1);
    d0 = dones;
    send(9'h0A5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send(9'h03C, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ready_low_when_held", m_rdy, 0);
    d_in = 8'hFF; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_drain(600);
    check("queue_two_dones", dones - d0, 2);

    // Reset mid-DATA with a queued character
    do_reset(2'd0, 1);
    send(9'h011, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(9'h022, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("mid_data_busy", m_bsy, 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_tx_high", m_tx, 1);
    check("abort_ready", m_rdy, 1);
    check("abort_busy", m_bsy, 0);
    f0 = frames;
    repeat (400) @(posedge clk);
    #1;
    check("abort_no_frame", frames - f0, 0);

    // tx_start held high with d_in changing every cycle: accepted at edges 0, 2, 162, 322
    do_reset(2'd0, 1);
    send_none();
    wait_drain(1000);

    check("no_stray_done", stray_done, 0);
    check("no_offtick_edges", glitches, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  task automatic send_none();
    exp_t e;
    logic [8:0] vals [4] = '{9'h05A, 9'h058, 9'h0F8, 9'h018};
    for (int i = 0; i < 4; i++) begin
      e.data = vals[i]; e.par = 1'b0; e.b2b = (i != 0);
      exp_q.push_back(e);
    end
    tx_start = 1'b1;
    d_in     = 8'h5A;
    for (int j = 1; j <= 331; j++) begin
      @(posedge clk); #1;
      d_in = 8'(j) ^ 8'h5A;
    end
    tx_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
